// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates N client channels onto a byte-wide RAM/IO bus
// and serialises byte/half/word transfers little-endian. Reads replay any
// un-captured bytes after an rdy pause, so captured bytes are never re-read.
module mem_port_arbiter #(
   parameter int unsigned N_CH   = 2,
   parameter int unsigned ARB_RR = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic [N_CH-1:0]      ch_req,
   input  logic [N_CH-1:0]      ch_we,
   input  logic [2*N_CH-1:0]    ch_width,
   input  logic [32*N_CH-1:0]   ch_addr,
   input  logic [32*N_CH-1:0]   ch_wdata,
   output logic [N_CH-1:0]      ch_done,
   output logic [31:0]          ch_rdata,
   output logic [N_CH-1:0]      ch_busy,
   input  logic [7:0]           mem_din,
   output logic [7:0]           mem_dout,
   output logic [31:0]          mem_a,
   output logic                 mem_wr
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [31:0]       base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        nbytes_q, nbytes_d;
   logic [2:0]        iss_q, iss_d;
   logic [2:0]        cap_q, cap_d;
   logic              vld_q, vld_d;
   logic              pend_q, pend_d;
   logic              replay_q, replay_d;
   logic [31:0]       acc_q, acc_d;
   logic [31:0]       a_q, a_d;
   logic [7:0]        dout_q, dout_d;
   logic              wr_q, wr_d;
   logic [N_CH-1:0]   done_q, done_d;
   logic [N_CH-1:0]   busy_q, busy_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [N_CH-1:0]   cand;
   logic              gnt_vld;
   logic [1:0]        gnt_idx;
   int unsigned       rot;
   logic              sel_we;
   logic [1:0]        sel_w;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic [2:0]        sel_n;
   logic [N_CH-1:0]   owner_oh;
   logic [N_CH-1:0]   gnt_oh;
   logic              eff_vld;
   logic [2:0]        eff_iss;
   logic [31:0]       acc_nxt;

   assign ch_done  = done_q;
   assign ch_busy  = busy_q;
   assign ch_rdata = rdata_q;
   assign mem_dout = dout_q;
   assign mem_wr   = wr_q & rdy;
   // On the first rdy-high cycle after a read pause the bus must already show
   // the first un-captured byte, so the replay address bypasses the register.
   assign mem_a    = (state_q == S_RD && replay_q && rdy) ? base_q + 32'(cap_q) : a_q;

   // Pick the winning channel among requesters not completing this cycle
   always_comb begin
      cand    = ch_req & ~done_q;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      rot     = 0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         rot = (ARB_RR != 0) ? (32'(ptr_q) + 32'd1 + i) % N_CH : i;
         for (int unsigned j = 0; j < N_CH; j++) begin
            if (!gnt_vld && j == rot && cand[j]) begin
               gnt_vld = 1'b1;
               gnt_idx = 2'(j);
            end
         end
      end
   end

   // Mux out the winner's request fields and build one-hot channel masks
   always_comb begin
      sel_we    = 1'b0;
      sel_w     = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      owner_oh  = '0;
      gnt_oh    = '0;
      for (int unsigned j = 0; j < N_CH; j++) begin
         owner_oh[j] = (2'(j) == owner_q);
         gnt_oh[j]   = (2'(j) == gnt_idx);
         if (2'(j) == gnt_idx) begin
            sel_we    = ch_we[j];
            sel_w     = ch_width[2*j +: 2];
            sel_addr  = ch_addr[32*j +: 32];
            sel_wdata = ch_wdata[32*j +: 32];
         end
      end
      case (sel_w)
         2'd0:    sel_n = 3'd1;
         2'd1:    sel_n = 3'd2;
         default: sel_n = 3'd4;
      endcase
   end

   // Next-state logic for grant, write serialisation and read issue/capture
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      base_d   = base_q;
      wdata_d  = wdata_q;
      nbytes_d = nbytes_q;
      iss_d    = iss_q;
      cap_d    = cap_q;
      vld_d    = vld_q;
      pend_d   = pend_q;
      replay_d = replay_q;
      acc_d    = acc_q;
      a_d      = a_q;
      dout_d   = dout_q;
      wr_d     = wr_q;
      done_d   = '0;
      busy_d   = busy_q;
      rdata_d  = rdata_q;
      eff_vld  = replay_q | vld_q;
      eff_iss  = replay_q ? cap_q : iss_q;
      acc_nxt  = acc_q;
      acc_nxt[8*cap_q[1:0] +: 8] = mem_din;

      if (!rdy) begin
         pend_d = 1'b0;
         if (state_q == S_RD) replay_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               pend_d = 1'b0;
               if (gnt_vld) begin
                  owner_d  = gnt_idx;
                  if (ARB_RR != 0) ptr_d = gnt_idx;
                  base_d   = sel_addr;
                  wdata_d  = sel_wdata;
                  nbytes_d = sel_n;
                  iss_d    = '0;
                  cap_d    = '0;
                  acc_d    = '0;
                  replay_d = 1'b0;
                  a_d      = sel_addr;
                  busy_d   = gnt_oh;
                  if (sel_we) begin
                     state_d = S_WR;
                     dout_d  = sel_wdata[7:0];
                     wr_d    = 1'b1;
                     vld_d   = 1'b0;
                  end else begin
                     state_d = S_RD;
                     wr_d    = 1'b0;
                     vld_d   = 1'b1;
                  end
               end
            end
            S_WR: begin
               if (iss_q + 3'd1 < nbytes_q) begin
                  iss_d  = iss_q + 3'd1;
                  a_d    = base_q + 32'(iss_q) + 32'd1;
                  dout_d = wdata_q[8*(iss_q[1:0] + 2'd1) +: 8];
               end else begin
                  wr_d    = 1'b0;
                  state_d = S_IDLE;
                  busy_d  = '0;
                  done_d  = owner_oh;
               end
            end
            S_RD: begin
               replay_d = 1'b0;
               pend_d   = eff_vld;
               if (eff_vld) begin
                  iss_d = eff_iss + 3'd1;
                  if (eff_iss + 3'd1 < nbytes_q) begin
                     a_d   = base_q + 32'(eff_iss) + 32'd1;
                     vld_d = 1'b1;
                  end else begin
                     a_d   = base_q + 32'(eff_iss);
                     vld_d = 1'b0;
                  end
               end
               if (pend_q) begin
                  acc_d = acc_nxt;
                  cap_d = cap_q + 3'd1;
                  if (cap_q + 3'd1 == nbytes_q) begin
                     state_d = S_IDLE;
                     done_d  = owner_oh;
                     busy_d  = '0;
                     rdata_d = acc_nxt;
                     vld_d   = 1'b0;
                     pend_d  = 1'b0;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         ptr_q    <= '0;
         base_q   <= '0;
         wdata_q  <= '0;
         nbytes_q <= '0;
         iss_q    <= '0;
         cap_q    <= '0;
         vld_q    <= 1'b0;
         pend_q   <= 1'b0;
         replay_q <= 1'b0;
         acc_q    <= '0;
         a_q      <= '0;
         dout_q   <= '0;
         wr_q     <= 1'b0;
         done_q   <= '0;
         busy_q   <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         base_q   <= base_d;
         wdata_q  <= wdata_d;
         nbytes_q <= nbytes_d;
         iss_q    <= iss_d;
         cap_q    <= cap_d;
         vld_q    <= vld_d;
         pend_q   <= pend_d;
         replay_q <= replay_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         dout_q   <= dout_d;
         wr_q     <= wr_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-channel round-robin instance with a
// synchronous byte RAM model, plus 3-channel round-robin and fixed instances.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic [1:0]  req = '0;
   logic [1:0]  we = '0;
   logic [3:0]  width = '0;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic [1:0]  done;
   logic [31:0] rdata;
   logic [1:0]  busy;
   logic [7:0]  mem_din = '0;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   logic [2:0]  req_rr = '0, req_fx = '0;
   logic [2:0]  done_rr, done_fx, busy_rr, busy_fx;
   logic [31:0] rdata_rr, rdata_fx, a_rr, a_fx;
   logic [7:0]  dout_rr, dout_fx;
   logic        wr_rr, wr_fx;

   logic [7:0]  ram [0:65535];
   logic [31:0] a_log [0:31];
   logic        wr_log [0:31];
   logic [7:0]  dout_log [0:31];
   logic        rdy_log [0:31];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) mem_din <= ram[mem_a[15:0]];

   mem_port_arbiter #(.N_CH(2), .ARB_RR(1)) u_dut (
      .clk(clk), .rst(rst), .rdy(rdy), .ch_req(req), .ch_we(we), .ch_width(width),
      .ch_addr(addr), .ch_wdata(wdata), .ch_done(done), .ch_rdata(rdata), .ch_busy(busy),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr));

   mem_port_arbiter #(.N_CH(3), .ARB_RR(1)) u_rr (
      .clk(clk), .rst(rst), .rdy(rdy), .ch_req(req_rr), .ch_we(3'b000), .ch_width(6'b0),
      .ch_addr(96'h0), .ch_wdata(96'h0), .ch_done(done_rr), .ch_rdata(rdata_rr), .ch_busy(busy_rr),
      .mem_din(8'h00), .mem_dout(dout_rr), .mem_a(a_rr), .mem_wr(wr_rr));

   mem_port_arbiter #(.N_CH(3), .ARB_RR(0)) u_fx (
      .clk(clk), .rst(rst), .rdy(rdy), .ch_req(req_fx), .ch_we(3'b000), .ch_width(6'b0),
      .ch_addr(96'h0), .ch_wdata(96'h0), .ch_done(done_fx), .ch_rdata(rdata_fx), .ch_busy(busy_fx),
      .mem_din(8'h00), .mem_dout(dout_fx), .mem_a(a_fx), .mem_wr(wr_fx));

   // Cycle 0 is the negedge where the request appears; cycle c is sampled at
   // the negedge after the c-th following posedge. Bits of low_mask drop rdy.
   task automatic run_txn(input int ch, input logic we_i, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] low_mask, output int dcyc, output logic [31:0] rd);
      @(negedge clk);
      dcyc = -1;
      rd   = '0;
      req = '0;
      req[ch] = 1'b1;
      we[ch] = we_i;
      width[2*ch +: 2] = w;
      addr[32*ch +: 32] = a;
      wdata[32*ch +: 32] = wd;
      for (int c = 1; c <= 30 && dcyc < 0; c++) begin
         @(posedge clk);
         #1 rdy = ~low_mask[c];
         @(negedge clk);
         a_log[c] = mem_a;
         wr_log[c] = mem_wr;
         dout_log[c] = mem_dout;
         rdy_log[c] = rdy;
         if (done[ch]) begin
            dcyc = c;
            rd = rdata;
         end
      end
      req = '0;
      rdy = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rdy = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
      n_checks++; if (mem_a !== 32'h0) begin n_errors++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
      n_checks++; if (mem_dout !== 8'h0) begin n_errors++; $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); end
      n_checks++; if (done !== 2'b00) begin n_errors++; $display("FAIL reset_done: got %b expected 00", done); end
      n_checks++; if (busy !== 2'b00) begin n_errors++; $display("FAIL reset_busy: got %b expected 00", busy); end
      n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word_read();
      int d; logic [31:0] rd;
      run_txn(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0, d, rd);
      for (int c = 1; c <= 4; c++) begin
         n_checks++;
         if (a_log[c] !== 32'h100 + 32'(c - 1) || wr_log[c] !== 1'b0) begin
            n_errors++; $display("FAIL word_read_addr c%0d: got %h/%b expected %h/0", c, a_log[c], wr_log[c], 32'h100 + 32'(c - 1));
         end
      end
      n_checks++; if (d !== 6) begin n_errors++; $display("FAIL word_read_done_cycle: got %0d expected 6", d); end
      n_checks++; if (rd !== 32'h44332211) begin n_errors++; $display("FAIL word_read_data: got %h expected 44332211", rd); end
   endtask

   task automatic test_half_write();
      int d; logic [31:0] rd;
      run_txn(1, 1'b1, 2'd1, 32'h201, 32'hAABBCCDD, 32'h0, d, rd);
      n_checks++; if ({wr_log[1], a_log[1], dout_log[1]} !== {1'b1, 32'h201, 8'hDD}) begin n_errors++; $display("FAIL half_write_b0: got %b %h %h expected 1 00000201 dd", wr_log[1], a_log[1], dout_log[1]); end
      n_checks++; if ({wr_log[2], a_log[2], dout_log[2]} !== {1'b1, 32'h202, 8'hCC}) begin n_errors++; $display("FAIL half_write_b1: got %b %h %h expected 1 00000202 cc", wr_log[2], a_log[2], dout_log[2]); end
      n_checks++; if (d !== 3) begin n_errors++; $display("FAIL half_write_done_cycle: got %0d expected 3", d); end
      n_checks++; if (wr_log[3] !== 1'b0) begin n_errors++; $display("FAIL half_write_wr_after: got %b expected 0", wr_log[3]); end
   endtask

   task automatic test_write_pause();
      int d; logic [31:0] rd;
      run_txn(0, 1'b1, 2'd2, 32'h300, 32'h04030201, 32'h4, d, rd);
      n_checks++; if (wr_log[2] !== 1'b0) begin n_errors++; $display("FAIL wpause_wr_low: got %b expected 0", wr_log[2]); end
      n_checks++; if ({a_log[3], dout_log[3], wr_log[3]} !== {32'h301, 8'h02, 1'b1}) begin n_errors++; $display("FAIL wpause_resume: got %h %h %b expected 00000301 02 1", a_log[3], dout_log[3], wr_log[3]); end
      n_checks++; if ({a_log[5], dout_log[5]} !== {32'h303, 8'h04}) begin n_errors++; $display("FAIL wpause_last: got %h %h expected 00000303 04", a_log[5], dout_log[5]); end
      n_checks++; if (d !== 6) begin n_errors++; $display("FAIL wpause_done_cycle: got %0d expected 6", d); end
   endtask

   task automatic test_read_pause();
      int d; int n100; logic [31:0] rd;
      run_txn(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h18, d, rd);
      n100 = 0;
      for (int c = 1; c <= 12; c++)
         if (c < d && rdy_log[c] && a_log[c] == 32'h100) n100++;
      n_checks++; if (d !== 9) begin n_errors++; $display("FAIL rpause_done_cycle: got %0d expected 9", d); end
      n_checks++; if (rd !== 32'h44332211) begin n_errors++; $display("FAIL rpause_data: got %h expected 44332211", rd); end
      n_checks++; if (n100 !== 1) begin n_errors++; $display("FAIL rpause_byte0_once: got %0d expected 1", n100); end
   endtask

   task automatic test_wrap_and_io();
      int d; logic [31:0] rd;
      run_txn(0, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, 32'h0, d, rd);
      n_checks++; if ({a_log[1], a_log[2]} !== {32'hFFFFFFFF, 32'h0}) begin n_errors++; $display("FAIL wrap_addr: got %h %h expected ffffffff 00000000", a_log[1], a_log[2]); end
      n_checks++; if (d !== 4) begin n_errors++; $display("FAIL wrap_done_cycle: got %0d expected 4", d); end
      n_checks++; if (rd !== 32'h00005AC3) begin n_errors++; $display("FAIL wrap_data: got %h expected 00005ac3", rd); end
      run_txn(1, 1'b0, 2'd0, 32'h30000, 32'h0, 32'h0, d, rd);
      n_checks++; if (a_log[1] !== 32'h30000) begin n_errors++; $display("FAIL io_addr: got %h expected 00030000", a_log[1]); end
      n_checks++; if (d !== 3) begin n_errors++; $display("FAIL io_done_cycle: got %0d expected 3", d); end
      n_checks++; if (rd !== 32'h0000005A) begin n_errors++; $display("FAIL io_data: got %h expected 0000005a", rd); end
   endtask

   task automatic test_back_to_back();
      int d1, d0a, d0b;
      logic [31:0] r1, r0a, r0b;
      logic b4, b7, b8;
      d1 = -1; d0a = -1; d0b = -1; r1 = '0; r0a = '0; r0b = '0; b4 = 1'b0; b7 = 1'b1; b8 = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      we = '0; width = '0;
      addr = {32'h101, 32'h100};
      req = 2'b11;
      for (int c = 1; c <= 20 && d0b < 0; c++) begin
         @(negedge clk);
         if (c == 4) b4 = busy[0];
         if (c == 7) b7 = busy[0];
         if (c == 8) b8 = busy[0];
         if (done[1]) begin d1 = c; r1 = rdata; req[1] = 1'b0; end
         if (done[0]) begin
            if (d0a < 0) begin d0a = c; r0a = rdata; end
            else begin d0b = c; r0b = rdata; req[0] = 1'b0; end
         end
      end
      req = '0;
      n_checks++; if (d1 !== 3 || r1 !== 32'h22) begin n_errors++; $display("FAIL b2b_first_ch1: got cycle %0d data %h expected 3 00000022", d1, r1); end
      n_checks++; if (b4 !== 1'b1) begin n_errors++; $display("FAIL b2b_grant_at_done: got busy0 %b expected 1", b4); end
      n_checks++; if (d0a !== 6 || r0a !== 32'h11) begin n_errors++; $display("FAIL b2b_second_ch0: got cycle %0d data %h expected 6 00000011", d0a, r0a); end
      n_checks++; if (b7 !== 1'b0 || b8 !== 1'b1) begin n_errors++; $display("FAIL b2b_same_ch_gap: got busy0 c7 %b c8 %b expected 0 1", b7, b8); end
      n_checks++; if (d0b !== 10 || r0b !== 32'h11) begin n_errors++; $display("FAIL b2b_repeat_ch0: got cycle %0d data %h expected 10 00000011", d0b, r0b); end
   endtask

   task automatic test_reset_mid_write();
      int d; int ndone; logic [31:0] rd;
      @(negedge clk);
      we = 2'b01; width = 4'b0010; addr = {32'h0, 32'h400}; wdata = {32'h0, 32'h12345678};
      req = 2'b01;
      @(negedge clk);
      n_checks++; if (mem_wr !== 1'b1) begin n_errors++; $display("FAIL rstw_started: got %b expected 1", mem_wr); end
      @(posedge clk);
      #1 rst = 1'b0; req = '0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      n_checks++; if ({mem_wr, busy, mem_a, mem_dout} !== {1'b0, 2'b00, 32'h0, 8'h0}) begin n_errors++; $display("FAIL rstw_outputs: got wr %b busy %b a %h dout %h expected 0 00 0 0", mem_wr, busy, mem_a, mem_dout); end
      ndone = 0;
      repeat (6) begin @(negedge clk); if (done != 2'b00) ndone++; end
      n_checks++; if (ndone !== 0) begin n_errors++; $display("FAIL rstw_no_done: got %0d pulses expected 0", ndone); end
      we = '0;
      run_txn(0, 1'b0, 2'd0, 32'h102, 32'h0, 32'h0, d, rd);
      n_checks++; if (d !== 3 || rd !== 32'h33) begin n_errors++; $display("FAIL rstw_recover_read: got cycle %0d data %h expected 3 00000033", d, rd); end
   endtask

   task automatic test_arbitration_modes();
      logic [11:0] seq_rr;
      int nrr, nfx, fx2;
      logic [1:0] fx_first, fx_third;
      seq_rr = '0; nrr = 0; nfx = 0; fx2 = 0; fx_first = 2'd3; fx_third = 2'd3;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      req_rr = 3'b111; req_fx = 3'b111;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         for (int j = 0; j < 3; j++) begin
            if (done_rr[j] && nrr < 6) begin seq_rr = {seq_rr[9:0], 2'(j)}; nrr++; end
            if (done_fx[j]) begin
               if (nfx == 0) fx_first = 2'(j);
               if (nfx == 2) fx_third = 2'(j);
               if (j == 2) fx2++;
               nfx++;
            end
         end
      end
      req_rr = '0; req_fx = '0;
      n_checks++; if (nrr !== 6 || seq_rr !== 12'b01_10_00_01_10_00) begin n_errors++; $display("FAIL rr_order: got %0d grants seq %b expected 6 011000011000", nrr, seq_rr); end
      n_checks++; if (fx_first !== 2'd0 || fx_third !== 2'd0) begin n_errors++; $display("FAIL fixed_ch0_priority: got %0d %0d expected 0 0", fx_first, fx_third); end
      n_checks++; if (fx2 !== 0 || nfx < 6) begin n_errors++; $display("FAIL fixed_ch2_starved: got ch2 %0d of %0d expected 0 of >=6", fx2, nfx); end
      @(negedge clk);
   endtask

   initial begin
      ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22;
      ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
      ram[16'hFFFF] = 8'hC3; ram[16'h0000] = 8'h5A;
      test_reset();
      test_word_read();
      test_half_write();
      test_write_pause();
      test_read_pause();
      test_wrap_and_io();
      test_back_to_back();
      test_reset_mid_write();
      test_arbitration_modes();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
